// File: rtl/rtmq_ppl_pkg.sv
// Shared helpers for the RTMQ pipeline arbiter: width derivation and tag type.
package rtmq_ppl_pkg;

   localparam int unsigned TAG_MAX_W = 16;

   // Widest tag the arbiter family supports; instances use the low tag_width() bits.
   typedef logic [TAG_MAX_W-1:0] tag_t;

   // Ceiling log2, clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   // Tag width for n requesters, at least one bit.
   function automatic int unsigned tag_width(input int unsigned n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   // Counter width able to hold 0..max_out inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_out);
      return (clog2(max_out + 1) < 1) ? 1 : clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/rtmq_rr_pick.sv
// Combinational round-robin picker: first eligible index after ptr, wrapping.
module rtmq_rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned W_TAG = 2
) (
   input  logic [N_REQ-1:0] elig,
   input  logic [W_TAG-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [W_TAG-1:0] idx,
   output logic             hit
);

   // Scan ptr+1 .. ptr+N_REQ; the last candidate is ptr itself.
   always_comb begin
      int unsigned pos;
      pos = 0;
      gnt = '0;
      idx = '0;
      hit = 1'b0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         pos = 32'(ptr) + k;
         if (pos >= N_REQ) pos = pos - N_REQ;
         if (!hit && elig[pos[W_TAG-1:0]]) begin
            gnt[pos[W_TAG-1:0]] = 1'b1;
            idx                 = pos[W_TAG-1:0];
            hit                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rtmq_ppl_arbiter.sv
// Round-robin arbiter feeding a shared tagged retiming pipeline with
// per-requester credit limits. Optional burst lock: RTMQ_PPL_ARB_LOCK_EN.
module rtmq_ppl_arbiter
   import rtmq_ppl_pkg::*;
#(
   parameter int unsigned W_BUS   = 32,
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned N_STG   = 2,
   parameter int unsigned MAX_OUT = 4,
   localparam int unsigned W_TAG  = tag_width(N_REQ),
   localparam int unsigned W_CNT  = cnt_width(MAX_OUT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*W_BUS-1:0] dat,
   output logic [N_REQ-1:0]       gnt,
   input  logic [N_REQ-1:0]       cpl,
`ifdef RTMQ_PPL_ARB_LOCK_EN
   input  logic [N_REQ-1:0]       lck,
`endif
   output logic                   out_vld,
   output logic [W_TAG-1:0]       out_tag,
   output logic [W_BUS-1:0]       out_dat,
   output logic                   err
);

   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] rr_gnt;
   logic [W_TAG-1:0] rr_idx;
   logic             rr_hit;
   logic [W_TAG-1:0] acc_idx;
   logic             acc_any;
   logic [W_BUS-1:0] dat_w [N_REQ];

   logic [W_TAG-1:0] ptr_q;
   logic [W_CNT-1:0] cnt_q [N_REQ];
   logic [W_CNT-1:0] cnt_d [N_REQ];
   logic             err_q;
   logic             err_d;

   logic             vld_q [N_STG];
   logic [W_TAG-1:0] tag_q [N_STG];
   logic [W_BUS-1:0] dat_q [N_STG];

`ifdef RTMQ_PPL_ARB_LOCK_EN
   logic             have_acc_q;
`endif

   // Unpack the flat data bus and form eligibility from registered credits.
   always_comb begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
         dat_w[i] = dat[i*W_BUS +: W_BUS];
         elig[i]  = req[i] && (cnt_q[i] < W_CNT'(MAX_OUT));
      end
   end

   rtmq_rr_pick #(
      .N_REQ (N_REQ),
      .W_TAG (W_TAG)
   ) u_pick (
      .elig (elig),
      .ptr  (ptr_q),
      .gnt  (rr_gnt),
      .idx  (rr_idx),
      .hit  (rr_hit)
   );

   // Final grant: round-robin result, overridden by an active burst lock.
   always_comb begin
      gnt     = rr_gnt;
      acc_idx = rr_idx;
      acc_any = rr_hit;
`ifdef RTMQ_PPL_ARB_LOCK_EN
      // ptr_q holds the last accepted requester once anything has been accepted.
      if (have_acc_q && elig[ptr_q] && lck[ptr_q]) begin
         gnt          = '0;
         gnt[ptr_q]   = 1'b1;
         acc_idx      = ptr_q;
         acc_any      = 1'b1;
      end
`endif
   end

   // Credit counters and sticky underflow error.
   always_comb begin
      err_d = err_q;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cnt_d[i] = cnt_q[i];
         case ({gnt[i] & req[i], cpl[i]})
            2'b10: cnt_d[i] = cnt_q[i] + W_CNT'(1);
            2'b01: begin
               if (cnt_q[i] == '0) err_d = 1'b1;
               else                cnt_d[i] = cnt_q[i] - W_CNT'(1);
            end
            default: ;
         endcase
      end
   end

   // Control state: rotation pointer, counters, error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= W_TAG'(N_REQ - 1);
         err_q <= 1'b0;
         for (int unsigned i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
      end else begin
         if (acc_any) ptr_q <= acc_idx;
         err_q <= err_d;
         for (int unsigned i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
      end
   end

`ifdef RTMQ_PPL_ARB_LOCK_EN
   // Remembers whether ptr_q names a real accept (it does not right after reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       have_acc_q <= 1'b0;
      else if (acc_any) have_acc_q <= 1'b1;
   end
`endif

   // Free-running retiming pipeline; stage 0 tag/data hold when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < N_STG; k++) begin
            vld_q[k] <= 1'b0;
            tag_q[k] <= '0;
            dat_q[k] <= '0;
         end
      end else begin
         vld_q[0] <= acc_any;
         if (acc_any) begin
            tag_q[0] <= acc_idx;
            dat_q[0] <= dat_w[acc_idx];
         end
         for (int unsigned k = 1; k < N_STG; k++) begin
            vld_q[k] <= vld_q[k-1];
            tag_q[k] <= tag_q[k-1];
            dat_q[k] <= dat_q[k-1];
         end
      end
   end

   assign out_vld = vld_q[N_STG-1];
   assign out_tag = tag_q[N_STG-1];
   assign out_dat = dat_q[N_STG-1];
   assign err     = err_q;

endmodule

// File: tb/tb_rtmq_ppl_arbiter.sv
// Directed bench for rtmq_ppl_arbiter (default parameters). Exercises the
// burst-lock path too when RTMQ_PPL_ARB_LOCK_EN is defined.
module tb_rtmq_ppl_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req;
   logic [127:0] dat;
   logic [3:0]   gnt;
   logic [3:0]   cpl;
`ifdef RTMQ_PPL_ARB_LOCK_EN
   logic [3:0]   lck;
`endif
   logic         out_vld;
   logic [1:0]   out_tag;
   logic [31:0]  out_dat;
   logic         err;

   int n_cmp = 0;
   int n_bad = 0;

   rtmq_ppl_arbiter dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .dat     (dat),
      .gnt     (gnt),
      .cpl     (cpl),
`ifdef RTMQ_PPL_ARB_LOCK_EN
      .lck     (lck),
`endif
      .out_vld (out_vld),
      .out_tag (out_tag),
      .out_dat (out_dat),
      .err     (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic do_reset();
      req = '0;
      cpl = '0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0]  exp_g;
      logic        exp_v;
      logic [1:0]  exp_t;
      rst_n = 1'b0;
      req   = '0;
      cpl   = '0;
      dat   = '0;
`ifdef RTMQ_PPL_ARB_LOCK_EN
      lck   = '0;
`endif
      repeat (2) @(negedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_vld", 32'(out_vld), 32'h0);
      chk("rst_tag", 32'(out_tag), 32'h0);
      chk("rst_dat", out_dat, 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         chk("idle_gnt", 32'(gnt), 32'h0);
         chk("idle_vld", 32'(out_vld), 32'h0);
         chk("idle_err", 32'(err), 32'h0);
      end

      // Single word from requester 0: two-cycle latency, one cycle wide.
      @(negedge clk);
      req = 4'b0001;
      dat[31:0] = 32'hA5A5_0001;
      #1 chk("single_gnt", 32'(gnt), 32'h1);
      @(negedge clk);
      req = '0;
      #1 chk("single_vld_early", 32'(out_vld), 32'h0);
      @(negedge clk); #1;
      chk("single_vld", 32'(out_vld), 32'h1);
      chk("single_tag", 32'(out_tag), 32'h0);
      chk("single_dat", out_dat, 32'hA5A5_0001);
      @(negedge clk); #1;
      chk("single_vld_late", 32'(out_vld), 32'h0);

      // All requesting from reset: 0,1,2,3 rotation until every credit is used.
      do_reset();
      for (int i = 0; i < 4; i++) dat[i*32 +: 32] = 32'hD000_0000 | 32'(i);
      for (int k = 0; k < 19; k++) begin
         @(negedge clk);
         if (k == 0) req = 4'b1111;
         #1;
         exp_g = (k < 16) ? (4'b0001 << (k % 4)) : 4'b0000;
         chk("rr_gnt", 32'(gnt), 32'(exp_g));
         if (k >= 2) begin
            exp_v = (k - 2) < 16;
            exp_t = 2'((k - 2) % 4);
            chk("rr_vld", 32'(out_vld), 32'(exp_v));
            if (exp_v) begin
               chk("rr_tag", 32'(out_tag), 32'(exp_t));
               chk("rr_dat", out_dat, 32'hD000_0000 | 32'(exp_t));
            end
         end
      end

      // Full requester 2 regains a credit; grant only the cycle after the return.
      @(negedge clk);
      cpl = 4'b0100;
      #1 chk("full_masked", 32'(gnt), 32'h0);
      @(negedge clk);
      cpl = '0;
      #1 chk("unmask_gnt2", 32'(gnt), 32'h4);
      @(negedge clk); #1;
      chk("refull_gnt", 32'(gnt), 32'h0);

      // Requester 1: accept and completion in the same cycle keep the count.
      @(negedge clk);
      cpl = 4'b0010;
      #1 chk("r1_masked", 32'(gnt), 32'h0);
      @(negedge clk); #1;
      chk("r1_acc_cpl", 32'(gnt), 32'h2);
      @(negedge clk);
      cpl = '0;
      #1 chk("r1_still", 32'(gnt), 32'h2);
      @(negedge clk); #1;
      chk("r1_full", 32'(gnt), 32'h0);
      chk("r1_err", 32'(err), 32'h0);

      // Completion with nothing outstanding: sticky error, counter untouched.
      do_reset();
      @(negedge clk);
      cpl = 4'b1000;
      #1 chk("err_pre", 32'(err), 32'h0);
      @(negedge clk);
      cpl = '0;
      #1 chk("err_set", 32'(err), 32'h1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("err_sticky", 32'(err), 32'h1);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0) req = 4'b1000;
         #1 chk("r3_credits", 32'(gnt), (k < 4) ? 32'h8 : 32'h0);
      end
      chk("err_hold", 32'(err), 32'h1);

      // Reset with two words in flight.
      do_reset();
      #1 chk("err_cleared", 32'(err), 32'h0);
      @(negedge clk);
      req = 4'b0011;
      #1 chk("fl_gnt0", 32'(gnt), 32'h1);
      @(negedge clk); #1;
      chk("fl_gnt1", 32'(gnt), 32'h2);
      @(negedge clk);
      req = '0;
      #1;
      chk("fl_vld", 32'(out_vld), 32'h1);
      chk("fl_tag", 32'(out_tag), 32'h0);
      chk("fl_dat", out_dat, 32'hD000_0000);
      #2 rst_n = 1'b0;
      #1;
      chk("async_vld", 32'(out_vld), 32'h0);
      chk("async_dat", out_dat, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("no_stale", 32'(out_vld), 32'h0);
      end

`ifdef RTMQ_PPL_ARB_LOCK_EN
      // Burst lock on requester 1 holds until its credits run out.
      begin
         logic [3:0] exp_l [6];
         exp_l = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
         do_reset();
         lck = 4'b0010;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) req = 4'b1111;
            #1 chk("lock_gnt", 32'(gnt), 32'(exp_l[k]));
         end
         req = '0;
         lck = '0;
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rtmq_ppl_arbiter.md
Name: rtmq_ppl_arbiter

Overview:
Round-robin arbiter that shares one W_BUS-wide, N_STG-deep register pipeline among N_REQ requesters. Tags each accepted word with its requester index and carries valid/tag alongside the data so the far end knows the source. Per-requester credit counters limit in-flight words; downstream returns credits with completion pulses. Sits between RTMQ core-side requesters and a slow/remote consumer reached through the retiming pipeline.

Parameters:
W_BUS, 32, data width per word
N_REQ, 4, number of requesters (>=2)
N_STG, 2, pipeline register stages (>=1); fixed accept-to-output latency
MAX_OUT, 4, max outstanding (accepted, not completed) words per requester (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
req  in  N_REQ  per-requester request, level
dat  in  N_REQ*W_BUS  request data, requester i at [i*W_BUS +: W_BUS]
gnt  out  N_REQ  one-hot grant, combinational from req/credits/pointer; word accepted when req[i]&gnt[i]
cpl  in  N_REQ  completion pulses from downstream, one credit return per bit per cycle
out_vld  out  1  pipeline output valid
out_tag  out  W_TAG  source index of output word, W_TAG = max(1,clog2(N_REQ))
out_dat  out  W_BUS  pipeline output data
err  out  1  sticky: cpl received for requester with zero outstanding

Behaviour:
- Reset (rst_n low, async): all pipeline vld/tag/dat stages 0 -> out_vld=0, out_tag=0, out_dat=0; counters 0; err=0; rr pointer = N_REQ-1 (requester 0 highest priority first). Reset mid-transfer drops in-flight words; no output after release until new accepts.
- Eligible(i) = req[i] && cnt[i] < MAX_OUT.
- Grant: first eligible index searching ptr+1, ptr+2, ... wrapping mod N_REQ; gnt all-zero if none eligible. At most one bit set.
- On accept of i: ptr <= i; stage0 <= {1, i, dat[i]}. No accept: stage0 vld <= 0 (tag/dat may hold). ptr unchanged without accept.
- Pipeline: stage k <= stage k-1 every cycle, no stall. Word accepted at edge t appears on out_* during cycle after edge t+N_STG-1 (N_STG cycles latency). Back-to-back accepts give back-to-back out_vld.
- Counters: cnt[i] +1 on accept of i, -1 on cpl[i], both same cycle -> unchanged. cpl[i] with cnt[i]==0 and no same-cycle accept: ignored, err <= 1 (sticky until reset). cnt width clog2(MAX_OUT+1).
- Credit full: cnt[i]==MAX_OUT masks i; cpl[i] in same cycle does NOT unmask in that cycle (eligibility uses registered cnt).
- Simultaneous cpl on multiple requesters handled independently.

Optional Feature:
Macro RTMQ_PPL_ARB_LOCK_EN. Defined: extra input port lck [N_REQ]; if requester i was last accepted and req[i]&&lck[i]&&eligible(i), gnt stays on i regardless of rotation (burst lock); lock breaks when lck[i] or req[i] drops or credits run out, then normal round-robin from ptr=i. Undefined: no lck port, pure round-robin every cycle.

Decomposition:
- Package rtmq_ppl_pkg: clog2 function, W_TAG/counter-width derivation helpers, tag typedef.
- Sub-module rtmq_rr_pick: combinational round-robin picker (eligible vector + pointer -> one-hot grant + index). Pipeline stages and counters stay in top.

Test Plan:
- Reset release, req=0 for 10 cycles -> gnt=0, out_vld=0, err=0 throughout.
- N_STG=2: req=4'b0001, dat0=0xA5A5_0001 single cycle -> gnt=0001 same cycle; out_vld=1, out_tag=0, out_dat=0xA5A5_0001 exactly 2 cycles later, one cycle wide.
- req=4'b1111 held, no cpl, MAX_OUT=4 -> grants 0,1,2,3,0,1,2,3,... 16 accepts then gnt=0 (all credits exhausted); output tags same order.
- Requester 2 at cnt=4: cpl[2] pulse -> cnt=3, gnt[2] next cycle; simultaneous accept and cpl on 1 -> cnt[1] unchanged.
- cpl[3] with cnt[3]=0 -> err=1, stays 1 until rst_n low; counters unaffected.
- rst_n asserted with 2 words in flight -> out_vld=0 immediately (async), no stale words after release; with RTMQ_PPL_ARB_LOCK_EN, req=1111, lck[1]=1 after grant to 1 -> four consecutive grants to 1 until credits exhausted, then 2.
